// File: rtl/vedic_pkg.sv
// Shared widths and helper functions for the vedic multiplier arbiter slice.
// Includes the Urdhva-Tiryagbhyam 2x2/4x4 building blocks.
package vedic_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    // Id width for NREQ requesters, never less than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = (n <= 2) ? 1 : $clog2(n);
        return r;
    endfunction

    function automatic logic [3:0] vedic2x2(input logic [1:0] a, input logic [1:0] b);
        logic       cross_s;
        logic       carry_s;
        logic [3:0] p_s;
        cross_s = (a[1] & b[0]) ^ (a[0] & b[1]);
        carry_s = (a[1] & b[0]) & (a[0] & b[1]);
        p_s[0]  = a[0] & b[0];
        p_s[1]  = cross_s;
        p_s[2]  = (a[1] & b[1]) ^ carry_s;
        p_s[3]  = (a[1] & b[1]) & carry_s;
        return p_s;
    endfunction

    function automatic logic [7:0] vedic4x4(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] q0_s;
        logic [3:0] q1_s;
        logic [3:0] q2_s;
        logic [3:0] q3_s;
        q0_s = vedic2x2(a[1:0], b[1:0]);
        q1_s = vedic2x2(a[3:2], b[1:0]);
        q2_s = vedic2x2(a[1:0], b[3:2]);
        q3_s = vedic2x2(a[3:2], b[3:2]);
        return {4'b0000, q0_s} + {2'b00, q1_s, 2'b00} + {2'b00, q2_s, 2'b00} + {q3_s, 4'b0000};
    endfunction

endpackage

// File: rtl/vedic8x8.sv
// Combinational 8x8 unsigned vedic multiplier assembled from four 4x4 blocks.
module vedic8x8
    import vedic_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] p
);

    logic [7:0] q0_s;
    logic [7:0] q1_s;
    logic [7:0] q2_s;
    logic [7:0] q3_s;

    assign q0_s = vedic4x4(a[3:0], b[3:0]);
    assign q1_s = vedic4x4(a[7:4], b[3:0]);
    assign q2_s = vedic4x4(a[3:0], b[7:4]);
    assign q3_s = vedic4x4(a[7:4], b[7:4]);

    // The exact product never exceeds 16 bits, so no carry out is lost.
    assign p = {8'h00, q0_s} + {4'h0, q1_s, 4'h0} + {4'h0, q2_s, 4'h0} + {q3_s, 8'h00};

endmodule

// File: rtl/vedic_rr_arbiter.sv
// Round-robin grant: first requester at or after rr_ptr, masked by en.
module vedic_rr_arbiter
    import vedic_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = clog2_min1(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic [IDW-1:0]  next_ptr
);

    logic           found_s;
    logic [IDW:0]   sum_s;
    logic [IDW-1:0] idx_s;

    // Scan NREQ positions starting at rr_ptr, wrapping modulo NREQ.
    always_comb begin
        found_s  = 1'b0;
        grant_id = '0;
        sum_s    = '0;
        idx_s    = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum_s = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (sum_s >= (IDW+1)'(NREQ)) begin
                sum_s = sum_s - (IDW+1)'(NREQ);
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[IDW-1:0];
            if (!found_s && req[idx_s]) begin
                found_s  = 1'b1;
                grant_id = idx_s;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // One-hot grant and the pointer that follows it.
    always_comb begin
        grant    = '0;
        next_ptr = rr_ptr;
        if (found_s && en) begin
            grant[grant_id] = 1'b1;
            next_ptr = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
        end else begin
            grant    = '0;
            next_ptr = rr_ptr;
        end
    end

endmodule

// File: rtl/vedic_mul_arbiter.sv
// Shares one vedic8x8 multiplier among NREQ requesters through a
// round-robin arbiter and a 2-stage (operand, product) pipeline.
module vedic_mul_arbiter
    import vedic_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = clog2_min1(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*OP_W-1:0]   req_a,
    input  logic [NREQ*OP_W-1:0]   req_b,
    output logic [NREQ-1:0]        req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [PROD_W-1:0]      rsp_prod,
    output logic                   busy
);

    logic              s1_valid_q, s1_valid_d;
    logic [OP_W-1:0]   s1_a_q, s1_a_d;
    logic [OP_W-1:0]   s1_b_q, s1_b_d;
    logic [IDW-1:0]    s1_id_q, s1_id_d;
    logic              s2_valid_q, s2_valid_d;
    logic [PROD_W-1:0] s2_prod_q, s2_prod_d;
    logic [IDW-1:0]    s2_id_q, s2_id_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;

    logic              s2_load_s;
    logic              s1_adv_s;
    logic              s1_load_s;
    logic              arb_en_s;
    logic              accept_s;
    logic [NREQ-1:0]   grant_s;
    logic [IDW-1:0]    grant_id_s;
    logic [IDW-1:0]    next_ptr_s;
    logic [PROD_W-1:0] mul_prod_s;

    assign s2_load_s = ~s2_valid_q | rsp_ready;
    assign s1_adv_s  = s1_valid_q & s2_load_s;
    assign s1_load_s = ~s1_valid_q | s1_adv_s;
    // Nothing is granted while reset is asserted.
    assign arb_en_s  = s1_load_s & ~rst;
    assign accept_s  = |grant_s;

    vedic_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req      (req_valid),
        .rr_ptr   (rr_ptr_q),
        .en       (arb_en_s),
        .grant    (grant_s),
        .grant_id (grant_id_s),
        .next_ptr (next_ptr_s)
    );

    vedic8x8 u_mul (
        .a (s1_a_q),
        .b (s1_b_q),
        .p (mul_prod_s)
    );

    // Next-state for both pipeline stages and the round-robin pointer.
    always_comb begin
        s1_valid_d = accept_s | (s1_valid_q & ~s1_adv_s);
        s2_valid_d = s1_adv_s | (s2_valid_q & ~rsp_ready);
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_id_d    = s1_id_q;
        rr_ptr_d   = rr_ptr_q;
        s2_prod_d  = s2_prod_q;
        s2_id_d    = s2_id_q;
        if (accept_s) begin
            s1_a_d   = req_a[grant_id_s*OP_W +: OP_W];
            s1_b_d   = req_b[grant_id_s*OP_W +: OP_W];
            s1_id_d  = grant_id_s;
            rr_ptr_d = next_ptr_s;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
        if (s1_adv_s) begin
            s2_prod_d = mul_prod_s;
            s2_id_d   = s1_id_q;
        end else begin
            s2_prod_d = s2_prod_q;
        end
    end

    // Pipeline and pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_prod_q  <= '0;
            s2_id_q    <= '0;
            rr_ptr_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_prod_q  <= s2_prod_d;
            s2_id_q    <= s2_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign req_ready = grant_s;
    assign rsp_valid = s2_valid_q;
    assign rsp_id    = s2_id_q;
    assign rsp_prod  = s2_prod_q;
    assign busy      = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_vedic_mul_arbiter.sv
// Directed and randomized self-checking bench for vedic_mul_arbiter (NREQ=4).
module tb_vedic_mul_arbiter;

    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_prod;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] prod;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    vedic_mul_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [15:0] exp_prod [4];
    logic [3:0]  exp_rdy;
    logic [15:0] p_v;
    exp_t        e_v;

    initial begin
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_a     = 32'h0;
        req_b     = 32'h0;
        rsp_ready = 1'b1;
        settle();
        check_eq("rst_ready", 32'(req_ready), 32'h0);
        tick();
        tick();
        settle();
        check_eq("rst_ready2", 32'(req_ready), 32'h0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_prod", 32'(rsp_prod), 32'h0);
        check_eq("rst_id", 32'(rsp_id), 32'h0);
        rst       = 1'b0;
        req_valid = 4'b0000;

        // Test 1: single max-operand product, two-cycle latency.
        tick();
        set_op(0, 8'hFF, 8'hFF);
        req_valid = 4'b0001;
        settle();
        check_eq("t1_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        check_eq("t1_lat1_valid", 32'(rsp_valid), 32'h0);
        tick();
        check_eq("t1_valid", 32'(rsp_valid), 32'h1);
        check_eq("t1_prod", 32'(rsp_prod), 32'hFE01);
        check_eq("t1_id", 32'(rsp_id), 32'h0);
        tick();
        check_eq("t1_drain_valid", 32'(rsp_valid), 32'h0);
        check_eq("t1_drain_busy", 32'(busy), 32'h0);

        // Test 2: all four valid, back-to-back accepts and responses.
        do_reset();
        set_op(0, 8'h0F, 8'hF0);
        set_op(1, 8'h00, 8'hA5);
        set_op(2, 8'h02, 8'h03);
        set_op(3, 8'h80, 8'h80);
        exp_prod[0] = 16'h0E10;
        exp_prod[1] = 16'h0000;
        exp_prod[2] = 16'h0006;
        exp_prod[3] = 16'h4000;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            settle();
            exp_rdy = (k < 4) ? (4'b0001 << k) : 4'b0000;
            check_eq($sformatf("t2_ready%0d", k), 32'(req_ready), 32'(exp_rdy));
            tick();
            if (k < 4) req_valid[k] = 1'b0;
            if (k >= 1) begin
                check_eq($sformatf("t2_valid%0d", k-1), 32'(rsp_valid), 32'h1);
                check_eq($sformatf("t2_prod%0d", k-1), 32'(rsp_prod), 32'(exp_prod[k-1]));
                check_eq($sformatf("t2_id%0d", k-1), 32'(rsp_id), 32'(k-1));
            end
        end
        tick();
        check_eq("t2_end_valid", 32'(rsp_valid), 32'h0);

        // Test 3: req0 and req2 held valid alternate grants.
        do_reset();
        set_op(0, 8'h07, 8'h09);
        set_op(2, 8'h0B, 8'h0D);
        req_valid = 4'b0101;
        for (int j = 0; j < 6; j++) begin
            settle();
            exp_rdy = (j % 2 == 0) ? 4'b0001 : 4'b0100;
            check_eq($sformatf("t3_ready%0d", j), 32'(req_ready), 32'(exp_rdy));
            tick();
        end
        req_valid = 4'b0000;
        tick();
        tick();
        tick();
        check_eq("t3_idle_busy", 32'(busy), 32'h0);

        // Test 4: backpressure fills the pipe, then release.
        do_reset();
        set_op(0, 8'h03, 8'h05);
        set_op(1, 8'h10, 8'h10);
        set_op(2, 8'hFF, 8'h02);
        req_valid = 4'b0111;
        rsp_ready = 1'b0;
        settle();
        check_eq("t4_ready0", 32'(req_ready), 32'h1);
        tick();
        req_valid[0] = 1'b0;
        settle();
        check_eq("t4_ready1", 32'(req_ready), 32'h2);
        tick();
        req_valid[1] = 1'b0;
        for (int s = 0; s < 4; s++) begin
            settle();
            check_eq("t4_full_ready", 32'(req_ready), 32'h0);
            check_eq("t4_full_valid", 32'(rsp_valid), 32'h1);
            check_eq("t4_full_prod", 32'(rsp_prod), 32'h000F);
            check_eq("t4_full_id", 32'(rsp_id), 32'h0);
            check_eq("t4_full_busy", 32'(busy), 32'h1);
            tick();
        end
        rsp_ready = 1'b1;
        settle();
        check_eq("t4_rel_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid[2] = 1'b0;
        check_eq("t4_r1_valid", 32'(rsp_valid), 32'h1);
        check_eq("t4_r1_prod", 32'(rsp_prod), 32'h0100);
        check_eq("t4_r1_id", 32'(rsp_id), 32'h1);
        tick();
        check_eq("t4_r2_valid", 32'(rsp_valid), 32'h1);
        check_eq("t4_r2_prod", 32'(rsp_prod), 32'h01FE);
        check_eq("t4_r2_id", 32'(rsp_id), 32'h2);
        tick();
        check_eq("t4_end_valid", 32'(rsp_valid), 32'h0);

        // Test 5: reset with both stages full, then pointer behaviour.
        do_reset();
        set_op(0, 8'h11, 8'h22);
        set_op(1, 8'h33, 8'h44);
        set_op(3, 8'h05, 8'h06);
        req_valid = 4'b0011;
        rsp_ready = 1'b0;
        tick();
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0000;
        check_eq("t5_pre_busy", 32'(busy), 32'h1);
        check_eq("t5_pre_valid", 32'(rsp_valid), 32'h1);
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        rsp_ready = 1'b1;
        check_eq("t5_rst_valid", 32'(rsp_valid), 32'h0);
        check_eq("t5_rst_busy", 32'(busy), 32'h0);
        req_valid = 4'b1000;
        settle();
        check_eq("t5_req3_first", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b0101;
        settle();
        check_eq("t5_wrap", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 4'b0101;
        settle();
        check_eq("t5_rst_ptr", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        tick();
        tick();

        // Test 6: random traffic against an acceptance-order scoreboard.
        do_reset();
        exp_q.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
                    set_op(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                    req_valid[i] = 1'b1;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            settle();
            check_eq("rnd_onehot", 32'($onehot0(req_ready)), 32'h1);
            check_eq("rnd_subset", 32'(req_ready & ~req_valid), 32'h0);
            if (rsp_valid && rsp_ready) begin
                check_eq("rnd_nonempty", 32'(exp_q.size() != 0), 32'h1);
                if (exp_q.size() != 0) begin
                    e_v = exp_q.pop_front();
                    check_eq("rnd_id", 32'(rsp_id), 32'(e_v.id));
                    check_eq("rnd_prod", 32'(rsp_prod), 32'(e_v.prod));
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    p_v  = 16'(req_a[8*i +: 8]) * 16'(req_b[8*i +: 8]);
                    e_v.id   = 2'(i);
                    e_v.prod = p_v;
                    exp_q.push_back(e_v);
                end
            end
            exp_rdy = req_ready;
            tick();
            req_valid = req_valid & ~exp_rdy;
        end
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        for (int d = 0; d < 10; d++) begin
            settle();
            if (rsp_valid) begin
                check_eq("drain_nonempty", 32'(exp_q.size() != 0), 32'h1);
                if (exp_q.size() != 0) begin
                    e_v = exp_q.pop_front();
                    check_eq("drain_id", 32'(rsp_id), 32'(e_v.id));
                    check_eq("drain_prod", 32'(rsp_prod), 32'(e_v.prod));
                end
            end
            tick();
        end
        check_eq("rnd_queue_empty", 32'(exp_q.size()), 32'h0);
        check_eq("rnd_busy_end", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
